// File: rtl/digit_scan_ctrl.sv
// rtl/digit_scan_ctrl.sv - time-multiplexed 4-digit scan controller with blanking and tear-free updates
module digit_scan_ctrl #(
  parameter int CLK_DIV   = 1000,
  parameter int BLANK_CYC = 16,
  parameter int CNT_W     = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        load,
  input  logic [15:0] digits,
  input  logic        lzb_en,
  output logic        dig_en,
  output logic [1:0]  dig_sel,
  output logic [3:0]  seg_code,
  output logic        frame_done
);

  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  state_t           state, nxt_state;
  logic [CNT_W-1:0] cnt, nxt_cnt;
  logic [1:0]       nxt_sel;
  logic [15:0]      active, nxt_active;
  logic [15:0]      pend;
  logic             pend_v;
  logic             slot_end;
  logic             wrap;

  function automatic logic [3:0] nibble_of(input logic [15:0] v, input logic [1:0] s);
    case (s)
      2'd0:    return v[3:0];
      2'd1:    return v[7:4];
      2'd2:    return v[11:8];
      default: return v[15:12];
    endcase
  endfunction

  // A digit is a leading zero when it and every more significant digit are zero
  function automatic logic lz_blank(input logic [15:0] v, input logic [1:0] s);
    case (s)
      2'd3:    return v[15:12] == 4'd0;
      2'd2:    return v[15:8] == 8'd0;
      2'd1:    return v[15:4] == 12'd0;
      default: return 1'b0;
    endcase
  endfunction

  // Next slot position and next displayed data; run=0 overrides everything
  always_comb begin
    slot_end  = (state == SHOW) && (cnt == SLOT_LAST);
    wrap      = run && slot_end && (dig_sel == 2'd3);
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_sel   = dig_sel;
    if (!run) begin
      nxt_state = IDLE;
      nxt_cnt   = '0;
      nxt_sel   = 2'd0;
    end else begin
      case (state)
        IDLE: begin
          nxt_state = BLANK;
          nxt_cnt   = '0;
          nxt_sel   = 2'd0;
        end
        BLANK: begin
          nxt_cnt = cnt + 1'b1;
          if (cnt == BLANK_LAST) nxt_state = SHOW;
        end
        SHOW: begin
          if (slot_end) begin
            nxt_cnt   = '0;
            nxt_sel   = dig_sel + 2'd1;
            nxt_state = BLANK;
          end else begin
            nxt_cnt = cnt + 1'b1;
          end
        end
        default: begin
          nxt_state = IDLE;
          nxt_cnt   = '0;
          nxt_sel   = 2'd0;
        end
      endcase
    end
    nxt_active = active;
    if (load && state == IDLE) nxt_active = digits;
    else if (wrap) nxt_active = load ? digits : (pend_v ? pend : active);
  end

  // Register scan state, data registers and all outputs from the next-state view
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      dig_sel    <= 2'd0;
      dig_en     <= 1'b0;
      seg_code   <= 4'd0;
      frame_done <= 1'b0;
      active     <= 16'd0;
      pend       <= 16'd0;
      pend_v     <= 1'b0;
    end else begin
      state      <= nxt_state;
      cnt        <= nxt_cnt;
      dig_sel    <= nxt_sel;
      active     <= nxt_active;
      seg_code   <= nibble_of(nxt_active, nxt_sel);
      dig_en     <= (nxt_state == SHOW) && !(lzb_en && lz_blank(nxt_active, nxt_sel));
      frame_done <= wrap;
      if (wrap) begin
        pend_v <= 1'b0;
      end else if (load && state != IDLE) begin
        pend   <= digits;
        pend_v <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// tb/tb_digit_scan_ctrl.sv - self-checking bench for digit_scan_ctrl
module tb_digit_scan_ctrl;

  localparam int CD    = 8;
  localparam int BC    = 2;
  localparam int FRAME = 4 * CD;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic        load;
  logic [15:0] digits;
  logic        lzb_en;
  logic        dig_en;
  logic [1:0]  dig_sel;
  logic [3:0]  seg_code;
  logic        frame_done;

  int n_chk;
  int n_fail;

  digit_scan_ctrl #(.CLK_DIV(CD), .BLANK_CYC(BC), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .load(load), .digits(digits),
    .lzb_en(lzb_en), .dig_en(dig_en), .dig_sel(dig_sel), .seg_code(seg_code),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: time since scan start, frame position by division
  bit          m_run;
  int          m_t;
  logic [15:0] m_act, m_pend;
  bit          m_pv;
  bit          m_fd, m_en;
  int          m_sel;
  int          m_seg;

  function automatic bit m_blank(input logic [15:0] a, input int k);
    return (k > 0) && ((a >> (4 * k)) == 16'd0);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 0; m_t = 0; m_act = 0; m_pend = 0; m_pv = 0; m_fd = 0;
    end else begin
      m_fd = 0;
      if (!run) begin
        if (load) begin
          if (m_run) begin m_pend = digits; m_pv = 1; end
          else m_act = digits;
        end
        m_run = 0;
        m_t = 0;
      end else if (!m_run) begin
        if (load) m_act = digits;
        m_run = 1;
        m_t = 0;
      end else begin
        m_t++;
        if (m_t % FRAME == 0) begin
          m_fd = 1;
          m_act = load ? digits : (m_pv ? m_pend : m_act);
          m_pv = 0;
        end else if (load) begin
          m_pend = digits;
          m_pv = 1;
        end
      end
    end
    m_sel = m_run ? (m_t / CD) % 4 : 0;
    m_en  = m_run && ((m_t % CD) >= BC) && !(lzb_en && m_blank(m_act, m_sel));
    m_seg = int'((m_act >> (4 * m_sel)) & 16'hF);
  end

  // Continuous comparison against the model away from the active edge
  always @(negedge clk) begin
    check("model_dig_en", int'(dig_en), int'(m_en));
    check("model_dig_sel", int'(dig_sel), m_sel);
    check("model_seg_code", int'(seg_code), m_seg);
    check("model_frame_done", int'(frame_done), int'(m_fd));
  end

  typedef struct {
    logic [15:0] d;
    logic        lzb;
    logic [15:0] exp_seg;
    logic [3:0]  exp_lit;
  } vec_t;

  vec_t tbl[7];

  task automatic start_with(input logic [15:0] d, input logic l);
    run = 0; load = 0;
    @(negedge clk);
    load = 1; digits = d; lzb_en = l;
    @(negedge clk);
    load = 0; run = 1;
    @(negedge clk);
  endtask

  task automatic wait_sel(input logic [1:0] s, input bit need_en, input string nm);
    int n = 0;
    while (!(dig_sel == s && (!need_en || dig_en)) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check({nm, "_timeout"}, n, 0);
  endtask

  task automatic wait_fd(input string nm);
    int n = 0;
    while (!frame_done && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check({nm, "_timeout"}, n, 0);
  endtask

  initial begin
    int lit_cnt[4];
    int seg_seen[4];
    int fd_cnt;
    int n;
    logic [15:0] d;
    n_chk = 0; n_fail = 0;
    rst_n = 0; run = 0; load = 0; digits = 0; lzb_en = 0;

    tbl[0] = '{16'h1234, 1'b0, 16'h1234, 4'b1111};
    tbl[1] = '{16'h0050, 1'b1, 16'h0050, 4'b0011};
    tbl[2] = '{16'h0000, 1'b1, 16'h0000, 4'b0001};
    tbl[3] = '{16'h0000, 1'b0, 16'h0000, 4'b1111};
    tbl[4] = '{16'h0A0F, 1'b1, 16'h0A0F, 4'b0111};
    tbl[5] = '{16'h00F0, 1'b0, 16'h00F0, 4'b1111};
    tbl[6] = '{16'h0100, 1'b1, 16'h0100, 4'b0111};

    @(negedge clk);
    check("reset_dig_en", int'(dig_en), 0);
    check("reset_dig_sel", int'(dig_sel), 0);
    check("reset_seg_code", int'(seg_code), 0);
    check("reset_frame_done", int'(frame_done), 0);
    rst_n = 1;

    // Table: one full frame per vector, lit cycles and nibble per slot
    for (int i = 0; i < 7; i++) begin
      start_with(tbl[i].d, tbl[i].lzb);
      fd_cnt = 0;
      for (int k = 0; k < 4; k++) begin lit_cnt[k] = 0; seg_seen[k] = -1; end
      for (int c = 0; c <= FRAME; c++) begin
        if (c < FRAME) begin
          lit_cnt[dig_sel] += int'(dig_en);
          seg_seen[dig_sel] = int'(seg_code);
        end
        fd_cnt += int'(frame_done);
        if (c < FRAME) @(negedge clk);
      end
      for (int k = 0; k < 4; k++) begin
        check($sformatf("tbl%0d_seg%0d", i, k), seg_seen[k], int'((tbl[i].exp_seg >> (4 * k)) & 16'hF));
        check($sformatf("tbl%0d_lit%0d", i, k), lit_cnt[k], tbl[i].exp_lit[k] ? CD - BC : 0);
      end
      check($sformatf("tbl%0d_frame_done", i), fd_cnt, 1);
    end

    // Mid-frame load is held back until the wrap
    start_with(16'h1234, 1'b0);
    wait_sel(2'd1, 1'b0, "t2_sel1");
    load = 1; digits = 16'h0056;
    @(negedge clk);
    load = 0;
    wait_sel(2'd2, 1'b1, "t2_sel2");
    check("t2_old_seg", int'(seg_code), 2);
    wait_fd("t2_wrap");
    check("t2_new_seg0", int'(seg_code), 6);
    wait_sel(2'd1, 1'b1, "t2_new_sel1");
    check("t2_new_seg1", int'(seg_code), 5);

    // run drop during a lit slot
    wait_sel(2'd2, 1'b1, "t4_sel2");
    run = 0;
    @(negedge clk);
    check("t4_dig_en", int'(dig_en), 0);
    check("t4_dig_sel", int'(dig_sel), 0);
    check("t4_frame_done", int'(frame_done), 0);
    run = 1;
    @(negedge clk);
    check("t4_restart_sel", int'(dig_sel), 0);
    check("t4_restart_blank", int'(dig_en), 0);

    // Load on the wrap cycle beats a pending load
    wait_sel(2'd1, 1'b0, "t5_sel1");
    load = 1; digits = 16'h9999;
    @(negedge clk);
    load = 0;
    n = 0;
    while (!(m_run && m_t % FRAME == FRAME - 1) && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) check("t5_wait_timeout", n, 0);
    load = 1; digits = 16'h4321;
    @(negedge clk);
    load = 0;
    check("t5_frame_done", int'(frame_done), 1);
    check("t5_seg0", int'(seg_code), 1);
    wait_sel(2'd1, 1'b0, "t5_sel1b");
    check("t5_seg1", int'(seg_code), 2);
    wait_fd("t5_wrap2");
    check("t5_pend_discarded", int'(seg_code), 1);

    // Asynchronous reset between clock edges
    wait_sel(2'd2, 1'b1, "t6_sel2");
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    check("t6_async_dig_en", int'(dig_en), 0);
    check("t6_async_dig_sel", int'(dig_sel), 0);
    check("t6_async_seg_code", int'(seg_code), 0);
    check("t6_async_frame_done", int'(frame_done), 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check("t6_resume_sel", int'(dig_sel), 0);
    check("t6_resume_blank", int'(dig_en), 0);

    // Randomized traffic checked by the model
    for (int c = 0; c < 1500; c++) begin
      run  = ($urandom % 64) != 0;
      load = ($urandom % 12) == 0;
      d = 16'($urandom);
      for (int k = 0; k < 4; k++) if ($urandom % 2 == 0) d[k*4 +: 4] = 4'd0;
      digits = d;
      if ($urandom % 40 == 0) lzb_en = ~lzb_en;
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
